// File: rtl/lfsr_backoff_ctrl_if.sv
// Request/draw bus between a retry requester, the LFSR and the backoff timer.
interface lfsr_backoff_ctrl_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned EXP_W = 4
);
  logic             start_i;
  logic             success_i;
  logic             abort_i;
  logic [WIDTH-1:0] rnd_i;
  logic             lfsr_en_o;
  logic             busy_o;
  logic             done_o;
  logic [EXP_W-1:0] exp_o;

  // Requester side: issues requests, supplies the LFSR value, sees status.
  modport master (
    output start_i, success_i, abort_i, rnd_i,
    input  lfsr_en_o, busy_o, done_o, exp_o
  );

  // Backoff timer side.
  modport slave (
    input  start_i, success_i, abort_i, rnd_i,
    output lfsr_en_o, busy_o, done_o, exp_o
  );
endinterface

// File: rtl/lfsr_backoff_ctrl.sv
// Randomised exponential-backoff timer. Draws a wait from the LFSR masked to
// a window of 2^exp-1, counts it down, pulses done and widens the window.
module lfsr_backoff_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MIN_EXP = 1,
  parameter int unsigned MAX_EXP = 10,
  parameter int unsigned EXP_W   = $clog2(MAX_EXP + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lfsr_backoff_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_DONE
  } state_t;

  localparam logic [EXP_W-1:0] MIN_E = EXP_W'(MIN_EXP);
  localparam logic [EXP_W-1:0] MAX_E = EXP_W'(MAX_EXP);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_cnt;
  logic [EXP_W-1:0] r_exp;
  logic             r_lfsr_en;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_draw;

  // Mask the random value to its low exp bits; masked-off bits are ANDed
  // with 0 so unknowns above the window cannot reach the counter.
  always_comb begin
    w_draw = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_draw[i] = bus.rnd_i[i] & (i < 32'(r_exp));
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_next = S_LOAD;
      S_LOAD: begin
        if (bus.abort_i)       w_next = S_IDLE;
        else if (w_draw == '0) w_next = S_DONE;
        else                   w_next = S_COUNT;
      end
      S_COUNT: begin
        if (bus.abort_i)                 w_next = S_IDLE;
        else if (r_cnt <= WIDTH'(1))     w_next = S_DONE;
        else                             w_next = S_COUNT;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; outputs are registered decodes of the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_lfsr_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_lfsr_en <= (w_next == S_LOAD);
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
    end
  end

  // Wait counter and window exponent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_exp <= MIN_E;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.success_i) r_exp <= MIN_E;
        end
        S_LOAD: begin
          if (bus.abort_i) r_cnt <= '0;
          else             r_cnt <= w_draw;
        end
        S_COUNT: begin
          if (bus.abort_i)        r_cnt <= '0;
          else if (r_cnt != '0)   r_cnt <= r_cnt - WIDTH'(1);
        end
        S_DONE: begin
          // An abort here still lets done_o out but keeps the window as is.
          if (bus.abort_i)        r_cnt <= '0;
          else if (r_exp < MAX_E) r_exp <= r_exp + EXP_W'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.lfsr_en_o = r_lfsr_en;
  assign bus.busy_o    = r_busy;
  assign bus.done_o    = r_done;
  assign bus.exp_o     = r_exp;

endmodule

// File: doc/lfsr_backoff_ctrl.md
Name: lfsr_backoff_ctrl

Overview:
- Randomised exponential-backoff timer placed directly downstream of the 16-bit LFSR.
- Consumes the LFSR state (`rnd_i`) and drives the LFSR advance enable (`lfsr_en_o`).
- Each request draws a wait count bounded by a window that doubles on every failed attempt, counts it down, then pulses `done_o`.
- Used by arbiters and retry logic to decorrelate competing requesters.

Parameters:
- WIDTH, 16, width of the random input. Must be >= MAX_EXP.
- MIN_EXP, 1, initial and post-success window exponent. Must be >= 1.
- MAX_EXP, 10, saturation exponent. Must be <= WIDTH. Window is 2^exp-1.
- EXP_W, $clog2(MAX_EXP+1), width of the exponent output (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  request a backoff wait. Accepted only in IDLE.
- success_i  in  1  last attempt succeeded; resets exponent. Honoured only in IDLE.
- abort_i  in  1  cancel an in-progress wait.
- rnd_i  in  WIDTH  random value from the LFSR output.
- lfsr_en_o  out  1  advance the LFSR; one-cycle pulse per draw.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the wait completes.
- exp_o  out  EXP_W  current window exponent.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, cnt=0, exp=MIN_EXP.
  - lfsr_en_o=busy_o=done_o=0; exp_o=MIN_EXP.
  - Overrides all other inputs. A reset during LOAD, COUNT or DONE gives IDLE next cycle with no done pulse.
- States: IDLE, LOAD, COUNT, DONE. All outputs are registered-state decodes (Moore).
- IDLE:
  - success_i=1: exp <= MIN_EXP.
  - start_i=1: next state LOAD.
  - start_i and success_i together: both take effect. LOAD then uses MIN_EXP.
  - abort_i is ignored in IDLE.
- LOAD (one cycle):
  - lfsr_en_o=1.
  - cnt <= rnd_i & ((1<<exp)-1), using the low exp bits.
  - Masked value is 0: next state DONE. Otherwise: next state COUNT.
- COUNT:
  - cnt decrements by 1 each cycle.
  - cnt==1: next state DONE.
  - cnt never wraps below 0.
- DONE (one cycle):
  - done_o=1.
  - exp <= min(exp+1, MAX_EXP).
  - Next state IDLE.
- Latency:
  - start_i accepted at cycle t, masked draw N.
  - lfsr_en_o at t+1; done_o at t+2+N; busy_o high t+1 .. t+2+N.
  - Earliest next accepted start is at t+3+N.
- abort_i:
  - In LOAD, COUNT or DONE: next state IDLE, cnt <= 0, exp unchanged.
  - Abort in DONE still emits that cycle's done_o, but the exp increment is suppressed.
  - An abort in LOAD still emits lfsr_en_o.
- start_i and success_i when not in IDLE: ignored, not queued.
- exp_o reflects the registered exp. It saturates at MAX_EXP and never wraps.
- rnd_i bits above exp are don't-care. X on those bits must not propagate.

Test Plan (WIDTH=16, MIN_EXP=1, MAX_EXP=10):
1. Reset 2 cycles, inputs idle 5 cycles -> busy_o=done_o=lfsr_en_o=0, exp_o=1 throughout.
2. rnd_i=16'hFFFF, start_i at cycle 0 -> lfsr_en_o at cycle 1, done_o only at cycle 3 (N=1); exp_o=2 from cycle 4.
3. rnd_i=16'h0000, start_i at cycle 0 -> done_o at cycle 2 (N=0), no COUNT cycles; exp_o increments to 2.
4. rnd_i=16'hFFFF, 12 back-to-back backoffs:
   - Waits are 1, 3, 7, ... 1023, 1023, 1023.
   - exp_o saturates at 10.
   - 12th done_o arrives 1025 cycles after its start.
5. exp=3, rnd_i=16'h0007, start at t, abort_i at t+4:
   - IDLE at t+5, no done_o, exp_o stays 3.
   - Then success_i -> exp_o=1 next cycle.
6. Mid-operation and simultaneous events:
   - exp=5, rst_i pulsed mid-COUNT -> IDLE next cycle, exp_o=1, no done_o.
   - Then start_i and success_i together -> draw masked to 1 bit.
   - start_i pulsed while busy -> ignored, exactly one done_o.
